// File: rtl/mips_pkg.sv
// Shared MIPS memory-op definitions for the EX/MM stage: opcodes, access size
// and the decode helpers used by the stage and its load aligner.
package mips_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} mem_size_e;

    function automatic logic is_load(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic mem_size_e op_size(input logic [5:0] op);
        mem_size_e sz;
        case (op)
            OP_LB, OP_LBU, OP_SB: sz = SZ_B;
            OP_LH, OP_LHU, OP_SH: sz = SZ_H;
            default:              sz = SZ_W;
        endcase
        return sz;
    endfunction

    // Only meaningful for memory ops; byte accesses can never be misaligned.
    function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] a);
        logic mis;
        case (op_size(op))
            SZ_H:    mis = a[0];
            SZ_W:    mis = (a != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ex_mm_stage_if.sv
// Data-memory port of the EX/MM stage: request/response handshake with a
// variable-latency memory.
interface ex_mm_stage_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ready, dmem_rdata
    );

endinterface

// File: rtl/ex_mm_stage_load_align.sv
// Big-endian load lane selection and sign/zero extension of a memory read word.
module load_align
    import mips_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  mem_size_e   size,
    input  logic        sgn,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Byte address 0 lives in bits 31:24.
    always_comb begin
        byte_sel = rdata[31:24];
        case (addr)
            2'd0: byte_sel = rdata[31:24];
            2'd1: byte_sel = rdata[23:16];
            2'd2: byte_sel = rdata[15:8];
            2'd3: byte_sel = rdata[7:0];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr[1] ? rdata[15:0] : rdata[31:16];
    end

    always_comb begin
        case (size)
            SZ_B:    data = {{24{sgn & byte_sel[7]}}, byte_sel};
            SZ_H:    data = {{16{sgn & half_sel[15]}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/ex_mm_stage.sv
// EX/MM pipeline register and data-memory access controller: issues loads and
// stores, stalls the front end on memory wait states, aligns load data.
module ex_mm_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_ex,
    input  logic        flush,
    input  logic [5:0]  opcode_ex,
    input  logic [31:0] pc_ex,
    input  logic [31:0] alu_result_ex,
    input  logic [31:0] store_data_ex,
    input  logic [4:0]  wr_num_ex,
    input  logic        wr_en_reg_ex,
    output logic        stall_mm,
    ex_mm_stage_if.master dmem,
    output logic [5:0]  opcode_ex_mm,
    output logic [31:0] pc_ex_mm,
    output logic [31:0] data_out_alu_ex_mm,
    output logic [4:0]  wr_num_ex_mm,
    output logic        wr_en_reg_ex_mm,
    output logic [31:0] data_out_mem,
    output logic        mem_fault
);

    typedef enum logic {IDLE, ACCESS} state_e;

    state_e            state;
    logic              vld_p0;
    logic [5:0]        opcode_p0;
    logic [31:0]       pc_p0;
    logic [31:0]       alu_p0;
    logic [31:0]       sdata_p0;
    logic [4:0]        wr_num_p0;
    logic              wr_en_p0;
    logic [CNT_W-1:0]  cnt;

    logic              in_vld;
    logic              in_access;
    logic              at_limit;
    logic              timeout;
    logic              misalign_p0;
    logic              load_sgn;
    mem_size_e         load_size;
    logic [31:0]       load_val;

    assign in_vld    = valid_ex & ~flush;
    assign in_access = in_vld && (is_load(opcode_ex) || is_store(opcode_ex))
                       && !is_misaligned(opcode_ex, alu_result_ex[1:0]);

    // Last permitted wait cycle: a missing ready here abandons the access.
    assign at_limit  = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout   = (state == ACCESS) && at_limit && !dmem.dmem_ready;
    assign stall_mm  = (state == ACCESS) && !dmem.dmem_ready && !at_limit;

    assign misalign_p0 = vld_p0 && (is_load(opcode_p0) || is_store(opcode_p0))
                         && is_misaligned(opcode_p0, alu_p0[1:0]);
    assign mem_fault   = misalign_p0 | timeout;

    assign load_size = op_size(opcode_p0);
    assign load_sgn  = (opcode_p0 == OP_LB) || (opcode_p0 == OP_LH);

    load_align u_load_align (
        .rdata (dmem.dmem_rdata),
        .addr  (alu_p0[1:0]),
        .size  (load_size),
        .sgn   (load_sgn),
        .data  (load_val)
    );

    // EX -> MM register boundary, FSM and wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            vld_p0       <= 1'b0;
            opcode_p0    <= '0;
            pc_p0        <= '0;
            alu_p0       <= '0;
            sdata_p0     <= '0;
            wr_num_p0    <= '0;
            wr_en_p0     <= 1'b0;
            cnt          <= '0;
            data_out_mem <= '0;
        end else begin
            if (!stall_mm) begin
                vld_p0    <= in_vld;
                opcode_p0 <= in_vld ? opcode_ex : 6'd0;
                wr_en_p0  <= in_vld & wr_en_reg_ex;
                pc_p0     <= pc_ex;
                alu_p0    <= alu_result_ex;
                sdata_p0  <= store_data_ex;
                wr_num_p0 <= wr_num_ex;
                cnt       <= '0;
                state     <= in_access ? ACCESS : IDLE;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if ((state == ACCESS) && dmem.dmem_ready && is_load(opcode_p0))
                data_out_mem <= load_val;
        end
    end

    // MM outputs: memory port and MM/WB fields
    assign dmem.dmem_req  = (state == ACCESS);
    assign dmem.dmem_we   = dmem.dmem_req && is_store(opcode_p0);
    assign dmem.dmem_addr = dmem.dmem_req ? {alu_p0[31:2], 2'b00} : 32'd0;

    always_comb begin
        dmem.dmem_be    = 4'b0000;
        dmem.dmem_wdata = 32'd0;
        if (dmem.dmem_req && is_store(opcode_p0)) begin
            case (opcode_p0)
                OP_SB: begin
                    dmem.dmem_be    = 4'b1000 >> alu_p0[1:0];
                    dmem.dmem_wdata = {4{sdata_p0[7:0]}};
                end
                OP_SH: begin
                    dmem.dmem_be    = alu_p0[1] ? 4'b0011 : 4'b1100;
                    dmem.dmem_wdata = {2{sdata_p0[15:0]}};
                end
                default: begin
                    dmem.dmem_be    = 4'b1111;
                    dmem.dmem_wdata = sdata_p0;
                end
            endcase
        end
    end

    // Stalled cycles look like bubbles downstream so each op retires once.
    assign opcode_ex_mm       = stall_mm ? 6'd0 : opcode_p0;
    assign wr_en_reg_ex_mm    = wr_en_p0 & ~stall_mm & ~mem_fault;
    assign pc_ex_mm           = pc_p0;
    assign data_out_alu_ex_mm = alu_p0;
    assign wr_num_ex_mm       = wr_num_p0;

endmodule

// File: tb/tb_ex_mm_stage.sv
// Bench for ex_mm_stage: directed cases plus randomized instruction stream
// against a behavioural memory-stage model.
module tb_ex_mm_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_ex = 1'b0;
    logic        flush = 1'b0;
    logic [5:0]  opcode_ex = '0;
    logic [31:0] pc_ex = '0;
    logic [31:0] alu_result_ex = '0;
    logic [31:0] store_data_ex = '0;
    logic [4:0]  wr_num_ex = '0;
    logic        wr_en_reg_ex = 1'b0;
    logic        stall_mm;
    logic [5:0]  opcode_ex_mm;
    logic [31:0] pc_ex_mm;
    logic [31:0] data_out_alu_ex_mm;
    logic [4:0]  wr_num_ex_mm;
    logic        wr_en_reg_ex_mm;
    logic [31:0] data_out_mem;
    logic        mem_fault;

    ex_mm_stage_if dmem ();

    ex_mm_stage #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .valid_ex           (valid_ex),
        .flush              (flush),
        .opcode_ex          (opcode_ex),
        .pc_ex              (pc_ex),
        .alu_result_ex      (alu_result_ex),
        .store_data_ex      (store_data_ex),
        .wr_num_ex          (wr_num_ex),
        .wr_en_reg_ex       (wr_en_reg_ex),
        .stall_mm           (stall_mm),
        .dmem               (dmem),
        .opcode_ex_mm       (opcode_ex_mm),
        .pc_ex_mm           (pc_ex_mm),
        .data_out_alu_ex_mm (data_out_alu_ex_mm),
        .wr_num_ex_mm       (wr_num_ex_mm),
        .wr_en_reg_ex_mm    (wr_en_reg_ex_mm),
        .data_out_mem       (data_out_mem),
        .mem_fault          (mem_fault)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_dout = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Access size in bytes; 0 for non-memory opcodes.
    function automatic int op_bytes(input logic [5:0] op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        if (op == OP_LW || op == OP_SW) return 4;
        return 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] addr,
                                             input logic [31:0] w);
        int          lane;
        logic [31:0] v;
        lane = int'(addr[1:0]);
        v = w;
        if (op_bytes(op) == 1) begin
            v = (w >> (8 * (3 - lane))) & 32'h0000_00FF;
            if (op == OP_LB && v[7]) v = v | 32'hFFFF_FF00;
        end else if (op_bytes(op) == 2) begin
            v = (w >> (8 * (2 - lane))) & 32'h0000_FFFF;
            if (op == OP_LH && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [3:0] ref_be(input logic [5:0] op, input logic [31:0] addr);
        logic [3:0] be;
        int         lane;
        lane = int'(addr[1:0]);
        be = 4'b0000;
        if (op == OP_SB) be[3 - lane] = 1'b1;
        else if (op == OP_SH) be = (lane < 2) ? 4'b1100 : 4'b0011;
        else be = 4'b1111;
        return be;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [5:0] op, input logic [31:0] sd);
        if (op == OP_SB) return {24'd0, sd[7:0]} * 32'h0101_0101;
        if (op == OP_SH) return {16'd0, sd[15:0]} * 32'h0001_0001;
        return sd;
    endfunction

    // Presents one instruction in EX, plays memory with wait_n wait states,
    // checks every cycle it spends in MM and the load result one cycle later.
    task automatic issue(input string tag, input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] sd, input logic [31:0] pc, input logic [4:0] rn,
                         input logic wen, input logic v, input logic fl,
                         input int wait_n, input logic [31:0] rd);
        int          nb;
        int          k;
        int          stalls;
        logic        real_i;
        logic        acc;
        logic        mis;
        logic        rdy;
        logic        to;
        logic        done;
        nb     = op_bytes(op);
        real_i = v && !fl;
        mis    = real_i && nb != 0 && (addr % nb) != 0;
        acc    = real_i && nb != 0 && !mis;
        k      = 0;
        stalls = 0;
        done   = 1'b0;
        valid_ex = v; flush = fl; opcode_ex = op; alu_result_ex = addr;
        store_data_ex = sd; pc_ex = pc; wr_num_ex = rn; wr_en_reg_ex = wen;
        @(posedge clk); #1;
        valid_ex = 1'b0; flush = 1'b0; opcode_ex = 6'($urandom);
        while (!done) begin
            rdy = acc && (k == wait_n);
            dmem.dmem_ready = rdy;
            dmem.dmem_rdata = rdy ? rd : $urandom;
            @(negedge clk);
            if (acc) begin
                to   = !rdy && (k == 15);
                done = rdy || to;
                chk({tag, ".req"}, dmem.dmem_req, 1);
                chk({tag, ".we"}, dmem.dmem_we, nb != 0 && op >= OP_SB);
                chk({tag, ".addr"}, dmem.dmem_addr, {addr[31:2], 2'b00});
                if (op >= OP_SB) begin
                    chk({tag, ".be"}, dmem.dmem_be, ref_be(op, addr));
                    chk({tag, ".wdata"}, dmem.dmem_wdata, ref_wdata(op, sd));
                end
                chk({tag, ".stall"}, stall_mm, !done);
                chk({tag, ".opc"}, opcode_ex_mm, done ? op : 6'd0);
                chk({tag, ".wren"}, wr_en_reg_ex_mm, (done && !to) ? wen : 1'b0);
                chk({tag, ".fault"}, mem_fault, to);
                if (!done) stalls++;
                if (rdy && op < OP_SB) exp_dout = ref_load(op, addr, rd);
            end else begin
                done = 1'b1;
                chk({tag, ".req"}, dmem.dmem_req, 0);
                chk({tag, ".stall"}, stall_mm, 0);
                chk({tag, ".fault"}, mem_fault, mis);
                chk({tag, ".opc"}, opcode_ex_mm, real_i ? op : 6'd0);
                chk({tag, ".wren"}, wr_en_reg_ex_mm, (real_i && !mis) ? wen : 1'b0);
            end
            if (done && real_i) begin
                chk({tag, ".pc"}, pc_ex_mm, pc);
                chk({tag, ".alu"}, data_out_alu_ex_mm, addr);
                chk({tag, ".rn"}, wr_num_ex_mm, rn);
            end
            // A flush arriving while the op is held must not disturb it.
            if (!done) flush = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            flush = 1'b0;
            k++;
        end
        dmem.dmem_ready = 1'b0;
        if (acc) chk({tag, ".nstall"}, stalls, (wait_n < 15) ? wait_n : 15);
        @(negedge clk);
        chk({tag, ".dout"}, data_out_mem, exp_dout);
        chk({tag, ".bub_stall"}, stall_mm, 0);
        chk({tag, ".bub_wren"}, wr_en_reg_ex_mm, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  op_tab [9];
        logic [5:0]  op;
        logic [31:0] addr;
        int          wn;
        op_tab = '{6'h00, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
        dmem.dmem_ready = 1'b0;
        dmem.dmem_rdata = '0;

        #2;
        chk("rst.req", dmem.dmem_req, 0);
        chk("rst.stall", stall_mm, 0);
        chk("rst.opc", opcode_ex_mm, 0);
        chk("rst.dout", data_out_mem, 0);
        chk("rst.fault", mem_fault, 0);
        chk("rst.wren", wr_en_reg_ex_mm, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue("lw0",  OP_LW,  32'h100, 0, 32'h400, 5'd3, 1, 1, 0, 0, 32'hDEADBEEF);
        issue("lb",   OP_LB,  32'h103, 0, 32'h404, 5'd4, 1, 1, 0, 1, 32'h123456F0);
        issue("lbu",  OP_LBU, 32'h103, 0, 32'h408, 5'd5, 1, 1, 0, 0, 32'h123456F0);
        issue("lh",   OP_LH,  32'h102, 0, 32'h40C, 5'd6, 1, 1, 0, 2, 32'h00008001);
        issue("sh",   OP_SH,  32'h202, 32'h0000ABCD, 32'h410, 5'd0, 0, 1, 0, 3, 0);
        issue("sb",   OP_SB,  32'h201, 32'h000000A5, 32'h414, 5'd0, 0, 1, 0, 0, 0);
        issue("lwto", OP_LW,  32'h300, 0, 32'h418, 5'd7, 1, 1, 0, 99, 0);
        issue("add",  6'h00,  32'h1234, 0, 32'h41C, 5'd8, 1, 1, 0, 0, 0);
        issue("lwmis", OP_LW, 32'h102, 0, 32'h420, 5'd9, 1, 1, 0, 0, 0);
        issue("flush", 6'h00, 32'h55, 0, 32'h424, 5'd10, 1, 1, 1, 0, 0);

        // Reset in the middle of a waiting load.
        valid_ex = 1'b1; opcode_ex = OP_LW; alu_result_ex = 32'h340;
        wr_en_reg_ex = 1'b1; wr_num_ex = 5'd11; pc_ex = 32'h428;
        @(posedge clk); #1;
        valid_ex = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid.req", dmem.dmem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("mid.req0", dmem.dmem_req, 0);
        chk("mid.stall", stall_mm, 0);
        chk("mid.opc", opcode_ex_mm, 0);
        chk("mid.pc", pc_ex_mm, 0);
        chk("mid.alu", data_out_alu_ex_mm, 0);
        chk("mid.wren", wr_en_reg_ex_mm, 0);
        chk("mid.dout", data_out_mem, 0);
        chk("mid.fault", mem_fault, 0);
        chk("mid.be", dmem.dmem_be, 0);
        exp_dout = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post.stall", stall_mm, 0);
        chk("post.req", dmem.dmem_req, 0);
        @(posedge clk); #1;
        issue("lwrst", OP_LW, 32'h344, 0, 32'h42C, 5'd12, 1, 1, 0, 1, 32'h0BADF00D);

        for (int i = 0; i < 40; i++) begin
            op   = op_tab[$urandom_range(0, 8)];
            addr = $urandom;
            if (op_bytes(op) > 1 && $urandom_range(0, 3) != 0)
                addr = addr & ~32'(op_bytes(op) - 1);
            wn = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 3));
            issue("rnd", op, addr, $urandom, $urandom, 5'($urandom), 1'($urandom),
                  $urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0, wn, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mm_stage.md
Name: ex_mm_stage

Overview:
- EX/MM pipeline register plus data-memory access controller.
- Sits between the ALU and the MM/WB register, and drives the data-memory port.
- Generates the byte-enables and store data, handles variable-latency memory with a stall back to the front end, and aligns and extends load data.
- Presents load data to the MM/WB boundary one cycle after the access completes, so it is valid during WB.

Parameters:
- TIMEOUT_CYCLES, 16: maximum wait cycles for dmem_ready before the access is abandoned as a fault.
- CNT_W, 5: width of the wait counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- valid_ex  in  1  EX holds a real instruction
- flush  in  1  squash the instruction being loaded from EX
- opcode_ex  in  6  MIPS opcode
- pc_ex  in  32  instruction PC
- alu_result_ex  in  32  ALU result, or effective address for loads/stores
- store_data_ex  in  32  rt value for stores
- wr_num_ex  in  5  destination register
- wr_en_reg_ex  in  1  register-write enable
- stall_mm  out  1  freeze PC/IF/ID/EX (combinational)
- dmem_req  out  1  memory request
- dmem_we  out  1  store
- dmem_addr  out  32  {addr[31:2],2'b00}
- dmem_be  out  4  byte enables; bit3 = byte lane 31:24
- dmem_wdata  out  32  lane-replicated store data
- dmem_ready  in  1  access complete this cycle
- dmem_rdata  in  32  read word, valid with dmem_ready
- opcode_ex_mm  out  6  to MM/WB
- pc_ex_mm  out  32  to MM/WB
- data_out_alu_ex_mm  out  32  to MM/WB
- wr_num_ex_mm  out  5  to MM/WB
- wr_en_reg_ex_mm  out  1  to MM/WB
- data_out_mem  out  32  aligned/extended load data, registered
- mem_fault  out  1  one-cycle pulse: misaligned access or timeout

Behaviour:
Reset (async, rst_n=0):
- Register contents, counter and data_out_mem all go to 0; state goes to IDLE.
- As a result, all outputs are 0 and dmem_req=0.
- A reset mid-access drops dmem_req immediately; the in-flight access is discarded with no fault.

Capture:
- On posedge clk with stall_mm=0, the register loads the EX fields.
- If valid_ex=0 or flush=1, it loads a bubble instead: opcode=0, wr_en=0, valid=0.
- When stall_mm=1 the register holds, and flush is ignored for the held instruction.

Memory ops (big-endian):
- Loads: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25.
- Stores: SB 0x28, SH 0x29, SW 0x2B.
- Misaligned means: halfword with addr[0]=1, or word with addr[1:0]!=0.

FSM:
- IDLE: entered when the register holds no memory op. Single-cycle pass-through, stall_mm=0.
- ACCESS: entered when the register holds a valid, aligned memory op.
  - dmem_req=1 and dmem_we=store; address, byte-enables and data are stable while the request is held.
  - dmem_ready=1 in the same cycle completes the access: stall_mm=0, return to IDLE or re-enter ACCESS for the next instruction.
  - Otherwise stall_mm=1 and the counter increments.
  - When the counter reaches TIMEOUT_CYCLES-1 without ready: complete, stall_mm=0, mem_fault=1, wr_en_reg_ex_mm=0, and dmem_req drops next cycle.
- Zero-wait memory therefore gives a one-cycle MM stage; each wait cycle adds exactly one stall cycle.

Misaligned access:
- No request is issued; completes in 1 cycle with mem_fault=1 and wr_en_reg_ex_mm=0.

Outputs to MM/WB:
- The five fields are driven from the register.
- While stall_mm=1, opcode_ex_mm=0 and wr_en_reg_ex_mm=0, so MM/WB sees bubbles and each instruction retires exactly once.

Store encoding:
- SB: be = 1000 >> addr[1:0]; wdata = byte replicated x4.
- SH: be = 1100 (addr[1]=0) or 0011 (addr[1]=1); wdata = halfword replicated x2.
- SW: be = 1111.

Load data:
- On the completing cycle of a load, data_out_mem is registered from dmem_rdata: the lane is selected by addr[1:0], sign-extended for LB/LH, zero-extended for LBU/LHU.
- data_out_mem holds until the next load completes; stores and ALU ops do not change it.

Decomposition:
- Package mips_pkg:
  - opcode localparams (OP_LB…OP_SW)
  - mem_size_e enum {SZ_B, SZ_H, SZ_W}
  - function is_load / is_store
- Sub-module load_align: combinational; inputs rdata, addr[1:0], size and signed flag; output is the 32-bit extended value.
- Everything else (register, FSM, counter, store encoding) lives in ex_mm_stage.

Test Plan:
- LW at addr 0x100, dmem_ready same cycle, rdata 0xDEADBEEF -> stall_mm stays 0; wr_en_reg_ex_mm=1 for 1 cycle; data_out_mem=0xDEADBEEF on the next cycle.
- LB at addr 0x103, rdata 0x123456F0 -> data_out_mem=0xFFFFFFF0; LBU at the same address -> 0x000000F0; LH at 0x102, rdata 0x00008001 -> 0xFFFF8001.
- SH at 0x202, store_data 0x0000ABCD, ready after 3 cycles -> dmem_be=0011, dmem_wdata=0xABCDABCD, dmem_addr=0x200; stall_mm=1 for exactly 3 cycles; opcode_ex_mm=0 during the stall.
- LW, dmem_ready never asserted -> stall_mm=1 for 15 cycles, then mem_fault pulses 1 cycle, wr_en_reg_ex_mm=0, next instruction enters.
- LW at 0x102 -> dmem_req never asserted, mem_fault=1 for 1 cycle, no stall; flush=1 while an ADD is in EX -> bubble in the register, wr_en_reg_ex_mm=0.
- rst_n low mid-wait on a LW -> dmem_req and all outputs 0 immediately; after release the FSM is IDLE and the next LW completes normally.
